alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU between two independent requesters (e.g. the execute stage and a multi-cycle helper unit).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block owns the ALU's SrcA/SrcB/Operation inputs and captures the ALU result.
- Grants alternate round-robin; one operation is in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the shared ALU.
- OPCODE_LENGTH, 4, ALU operation code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  OPCODE_LENGTH  requester 0 ALU operation.
- req0_a  in  DATA_WIDTH  requester 0 operand A.
- req0_b  in  DATA_WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp1_valid  out  1  result for requester 1 available.
- rsp1_ready  in  1  requester 1 consumes result.
- rsp_data  out  DATA_WIDTH  registered result; shared by both response channels.
- alu_srca  out  DATA_WIDTH  to ALU SrcA.
- alu_srcb  out  DATA_WIDTH  to ALU SrcB.
- alu_operation  out  OPCODE_LENGTH  to ALU Operation.
- alu_result  in  DATA_WIDTH  from ALU ALUResult (combinational).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - state = IDLE.
  - last_grant = 1, so requester 0 wins first.
  - owner = 0.
  - All operand/op registers = 0; rsp_data = 0.
  - rsp0_valid = rsp1_valid = 0; busy = 0.
- IDLE: select a winner.
  - Only one valid requester: it wins.
  - Both valid: winner = !last_grant.
  - reqX_ready = 1 combinationally for the winner only, and only in IDLE.
  - On the handshake: capture op/a/b into registers, set owner = winner, set last_grant = winner, go to EXEC.
  - No valid requester: stay in IDLE; both ready signals = 0.
- EXEC (exactly one cycle):
  - alu_srca/alu_srcb/alu_operation driven from the captured registers.
  - rsp_data <= alu_result at the clock edge; go to RESP.
- RESP:
  - rsp{owner}_valid = 1; the other response valid stays 0.
  - rsp_data is held stable.
  - On rsp{owner}_ready = 1, go to IDLE; the valid drops the next cycle.
  - Without ready, hold indefinitely.
  - Requests are not accepted in RESP or EXEC; ready stays 0.
- Latency: accept edge at cycle N -> rsp valid from cycle N+2.
  - Minimum 3 cycles per operation when the consumer is always ready.
- ALU-side outputs hold the last captured values outside EXEC, so there is no toggling while idle.
- Opcodes are forwarded unchecked. Undefined codes produce whatever the ALU returns (0 for the current ALU). Supported codes: AND 0000, OR 0001, ADD 0010, EQ 1000, XOR 1001.
- Requester protocol rules:
  - A requester may drop valid before ready with no effect.
  - Once accepted, the operands are owned by the arbiter; later input changes are ignored.
- Reset asserted mid-operation (any state):
  - Immediate return to IDLE.
  - The in-flight operation is discarded and no response is issued.
  - last_grant returns to 1.
- Simultaneous events:
  - A new request arriving while in RESP waits; it is not lost as long as the requester holds valid.
  - A requester receiving its response may present its next request in the same cycle it asserts rsp_ready. That request is accepted in the following IDLE cycle, subject to round-robin.

Test Plan:
- Reset then req0 only: ADD a=5, b=7 -> req0_ready high 1 cycle, alu_operation=0010 in EXEC, rsp0_valid with rsp_data=12 two cycles after accept; rsp1_valid stays 0.
- Both valid every cycle (req0 AND 0xF0F0/0x0FF0, req1 XOR 0xFFFF/0x00FF), rsp ready tied 1 -> grants alternate 0,1,0,1; results 0x00F0 and 0xFF00 on the correct channel; each op takes 3 cycles.
- Backpressure: req1 EQ a=9, b=9 with rsp1_ready low 5 cycles -> rsp1_valid and rsp_data=1 held stable, busy=1, req0_ready=0 throughout; completes one cycle after ready rises.
- req0 OR 0x1/0x2 and req0 operands changed to 0xFF/0xFF the cycle after accept -> rsp_data=3.
- Reset pulse in EXEC with req1 ADD pending -> no rsp valid; after release, both requesting -> req0 granted first.
- Undefined opcode 0111 -> response issued normally with rsp_data=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     last_grant;
  logic                     owner;
  logic                     grant0;
  logic                     grant1;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]    a_q;
  logic [DATA_WIDTH-1:0]    b_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;

  // Winner selection in IDLE and next-state decode
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        // On contention the requester not granted last time wins
        if (req0_valid && (!req1_valid || last_grant)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if ((!owner && rsp0_ready) || (owner && rsp1_ready)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture on accept, result capture at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
    end else begin
      if (grant0) begin
        op_q       <= req0_op;
        a_q        <= req0_a;
        b_q        <= req0_b;
        owner      <= 1'b0;
        last_grant <= 1'b0;
      end else if (grant1) begin
        op_q       <= req1_op;
        a_q        <= req1_a;
        b_q        <= req1_b;
        owner      <= 1'b1;
        last_grant <= 1'b1;
      end
      if (state == EXEC) begin
        rsp_data_q <= alu_result;
      end
    end
  end

  // ALU inputs come straight from the capture registers so they stay quiet when idle
  assign alu_srca      = a_q;
  assign alu_srcb      = b_q;
  assign alu_operation = op_q;

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [OL-1:0] req0_op = '0;
  logic [DW-1:0] req0_a = '0;
  logic [DW-1:0] req0_b = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [OL-1:0] req1_op = '0;
  logic [DW-1:0] req1_a = '0;
  logic [DW-1:0] req1_b = '0;
  logic          rsp0_valid;
  logic          rsp0_ready = 1'b1;
  logic          rsp1_valid;
  logic          rsp1_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] alu_srca;
  logic [DW-1:0] alu_srcb;
  logic [OL-1:0] alu_operation;
  logic [DW-1:0] alu_result;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [DW:0] exp_q[$];

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_operation(alu_operation), .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model of the shared ALU
  always_comb begin
    case (alu_operation)
      4'b0000: alu_result = alu_srca & alu_srcb;
      4'b0001: alu_result = alu_srca | alu_srcb;
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b1000: alu_result = {31'd0, alu_srca == alu_srcb};
      4'b1001: alu_result = alu_srca ^ alu_srcb;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rsp0_valid && rsp1_valid) check("both_rsp_valid", 1, 0);
      else if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (exp_q.size() == 0) check("unexpected_rsp", {rsp1_valid, rsp_data}, '1);
        else check("rsp", {rsp1_valid, rsp_data}, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input bit ch);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if ((ch ? req1_ready : req0_ready) === 1'b1) break;
    end
    if (k == 50) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    if (k == 50) check("idle_timeout", 0, 1);
  endtask

  // Issue a single request; returns just after the accepting edge with valid dropped
  task automatic issue(input bit ch, input logic [OL-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] exp, input bit push);
    @(posedge clk); #1;
    if (ch) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    wait_ready(ch);
    if (push) exp_q.push_back({ch, exp});
    @(posedge clk); #1;
    if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Both requesters hold valid; grants must alternate starting at requester 0, 3 cycles apart
  task automatic alternate(input int n, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    int last_cyc;
    bit exp_ch;
    last_cyc = 0;
    exp_ch = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      int t;
      for (t = 0; t < 20; t++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) break;
      end
      if (t == 20) check("alt_timeout", 0, 1);
      check("alt_grant", {req1_ready, req0_ready}, exp_ch ? 2'b10 : 2'b01);
      if (k > 0) check("alt_period", cyc - last_cyc, 3);
      last_cyc = cyc;
      exp_q.push_back({exp_ch, exp_ch ? e1 : e0});
      exp_ch = ~exp_ch;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_alu_srca", alu_srca, 0);
    check("rst_alu_op", alu_operation, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // req0 ADD 5+7, latency and ALU drive
    issue(1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b1);
    @(negedge clk);
    check("exec_op", alu_operation, 4'b0010);
    check("exec_srca", alu_srca, 5);
    check("exec_srcb", alu_srcb, 7);
    check("exec_busy", busy, 1);
    check("exec_rsp0", rsp0_valid, 0);
    check("exec_ready", req0_ready, 0);
    @(negedge clk);
    check("resp_rsp0", rsp0_valid, 1);
    check("resp_rsp1", rsp1_valid, 0);
    check("resp_data", rsp_data, 12);
    wait_idle();
    check("idle_srca_held", alu_srca, 5);

    // Contention, alternating grants
    do_reset();
    req0_op = 4'b0000; req0_a = 32'hF0F0; req0_b = 32'h0FF0;
    req1_op = 4'b1001; req1_a = 32'hFFFF; req1_b = 32'h00FF;
    alternate(4, 32'h00F0, 32'hFF00);
    wait_idle();

    // Backpressure on requester 1 with requester 0 waiting
    rsp1_ready = 1'b0;
    issue(1'b1, 4'b1000, 32'd9, 32'd9, 32'd1, 1'b1);
    req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
    @(negedge clk);
    check("bp_exec_ready0", req0_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp_data", rsp_data, 1);
      check("bp_busy", busy, 1);
      check("bp_ready0", req0_ready, 0);
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_ready0_last", req0_ready, 0);
    @(negedge clk);
    check("bp_rsp1_drop", rsp1_valid, 0);
    check("bp_ready0_after", req0_ready, 1);
    exp_q.push_back({1'b0, 32'd2});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_idle();

    // Operand changes after accept are ignored
    issue(1'b0, 4'b0001, 32'h1, 32'h2, 32'd3, 1'b1);
    req0_a = 32'hFF; req0_b = 32'hFF;
    @(negedge clk);
    check("own_srca", alu_srca, 1);
    wait_idle();

    // Reset in EXEC discards the operation and restores round-robin priority
    issue(1'b1, 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_exec_busy", busy, 0);
    check("rst_exec_rsp1", rsp1_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_rsp", {rsp1_valid, rsp0_valid}, 0);
    end
    req0_op = 4'b0000; req0_a = 32'hF0F0; req0_b = 32'h0FF0;
    req1_op = 4'b1001; req1_a = 32'h1; req1_b = 32'h1;
    alternate(2, 32'h00F0, 32'h0);
    wait_idle();

    // Undefined opcode passes through
    issue(1'b0, 4'b0111, 32'd5, 32'd3, 32'd0, 1'b1);
    @(negedge clk);
    check("undef_op", alu_operation, 4'b0111);
    wait_idle();

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
